// File: rtl/axi_llc_pkg.sv
// Shared definitions for the LLC flush sequencer: FSM state encoding,
// default register offsets and a small state-classification helper.
package axi_llc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WR_FLUSH  = 3'd1;
  localparam state_t ST_WR_COMMIT = 3'd2;
  localparam state_t ST_WAIT      = 3'd3;
  localparam state_t ST_RD_STATUS = 3'd4;
  localparam state_t ST_FINISH    = 3'd5;

  localparam logic [31:0] DefaultBaseAddr      = 32'h0000_0000;
  localparam logic [31:0] DefaultFlushOffset   = 32'h0000_0008;
  localparam logic [31:0] DefaultCommitOffset  = 32'h0000_0010;
  localparam logic [31:0] DefaultFlushedOffset = 32'h0000_0018;

  // True in the states that own an outstanding RegBus transfer.
  function automatic logic is_xfer_state(input state_t st);
    return (st == ST_WR_FLUSH) || (st == ST_WR_COMMIT) || (st == ST_RD_STATUS);
  endfunction

endpackage

// File: rtl/axi_llc_flush_seq.sv
// LLC flush sequencer: writes the way mask and commit over RegBus, then
// polls the flushed-status register until all requested ways report clean.
module axi_llc_flush_seq
  import axi_llc_pkg::*;
#(
  parameter int unsigned SetAssociativity = 32'd8,
  parameter logic [31:0] BaseAddr         = DefaultBaseAddr,
  parameter logic [31:0] FlushOffset      = DefaultFlushOffset,
  parameter logic [31:0] CommitOffset     = DefaultCommitOffset,
  parameter logic [31:0] FlushedOffset    = DefaultFlushedOffset,
  parameter int unsigned PollInterval     = 32'd16,
  parameter int unsigned MaxPolls         = 32'd1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [SetAssociativity-1:0] ways_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [31:0]                 reg_addr_o,
  output logic                        reg_write_o,
  output logic [31:0]                 reg_wdata_o,
  output logic [3:0]                  reg_wstrb_o,
  output logic                        reg_valid_o,
  input  logic [31:0]                 reg_rdata_i,
  input  logic                        reg_error_i,
  input  logic                        reg_ready_i
);

  localparam int unsigned PollW = $clog2(MaxPolls + 32'd1);
  localparam int unsigned WaitW = $clog2(PollInterval + 32'd1);

  localparam logic [31:0]      FlushAddr  = BaseAddr + FlushOffset;
  localparam logic [31:0]      CommitAddr = BaseAddr + CommitOffset;
  localparam logic [31:0]      StatusAddr = BaseAddr + FlushedOffset;
  localparam logic [PollW-1:0] PollLimit  = PollW'(MaxPolls);
  localparam logic [WaitW-1:0] WaitLoad   = WaitW'(PollInterval);

  state_t           state_q, state_d;
  logic [31:0]      mask_q, mask_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, err_d;
  logic [PollW-1:0] poll_inc_s;
  logic             xfer_done_s;
  logic             status_ok_s;

  assign xfer_done_s = is_xfer_state(state_q) & reg_ready_i;
  assign status_ok_s = (reg_rdata_i & mask_q) == mask_q;
  assign poll_inc_s  = poll_q + PollW'(1'b1);

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_FINISH);
  assign err_o  = err_q;

  // Request fields are a pure function of state and mask; all zero when not valid.
  always_comb begin
    reg_valid_o = 1'b0;
    reg_write_o = 1'b0;
    reg_addr_o  = 32'h0000_0000;
    reg_wdata_o = 32'h0000_0000;
    reg_wstrb_o = 4'h0;
    case (state_q)
      ST_WR_FLUSH: begin
        reg_valid_o = 1'b1;
        reg_write_o = 1'b1;
        reg_addr_o  = FlushAddr;
        reg_wdata_o = mask_q;
        reg_wstrb_o = 4'hF;
      end
      ST_WR_COMMIT: begin
        reg_valid_o = 1'b1;
        reg_write_o = 1'b1;
        reg_addr_o  = CommitAddr;
        reg_wdata_o = 32'h0000_0001;
        reg_wstrb_o = 4'hF;
      end
      ST_RD_STATUS: begin
        reg_valid_o = 1'b1;
        reg_addr_o  = StatusAddr;
      end
      default: begin
        reg_valid_o = 1'b0;
      end
    endcase
  end

  // Sequencer next-state logic; a bus error at any completion aborts to FINISH.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    poll_d  = poll_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mask_d = 32'(ways_i);
          err_d  = 1'b0;
          if (ways_i == {SetAssociativity{1'b0}}) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_WR_FLUSH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_FLUSH: begin
        if (xfer_done_s) begin
          if (reg_error_i) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_WR_COMMIT;
          end
        end else begin
          state_d = ST_WR_FLUSH;
        end
      end
      ST_WR_COMMIT: begin
        if (xfer_done_s) begin
          if (reg_error_i) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            poll_d  = {PollW{1'b0}};
            wait_d  = WaitLoad;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_WR_COMMIT;
        end
      end
      ST_WAIT: begin
        if (wait_q <= WaitW'(1'b1)) begin
          wait_d  = {WaitW{1'b0}};
          state_d = ST_RD_STATUS;
        end else begin
          wait_d  = wait_q - WaitW'(1'b1);
        end
      end
      ST_RD_STATUS: begin
        if (xfer_done_s) begin
          if (reg_error_i) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else if (status_ok_s) begin
            state_d = ST_FINISH;
          end else if (poll_inc_s < PollLimit) begin
            poll_d  = poll_inc_s;
            wait_d  = WaitLoad;
            state_d = ST_WAIT;
          end else begin
            poll_d  = poll_inc_s;
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end
        end else begin
          state_d = ST_RD_STATUS;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any outstanding transfer at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mask_q  <= 32'h0000_0000;
      poll_q  <= {PollW{1'b0}};
      wait_q  <= {WaitW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      poll_q  <= poll_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_llc_flush_seq.sv
// Self-checking bench for axi_llc_flush_seq: a RegBus responder with random
// ready latency and a transaction-level model of the expected flush sequence.
module tb_axi_llc_flush_seq;

  localparam int WAYS      = 8;
  localparam int POLL      = 16;
  localparam int MAX_POLLS = 4;
  localparam int BUDGET    = 400;
  localparam logic [31:0] FLUSH_ADDR  = 32'h0000_0008;
  localparam logic [31:0] COMMIT_ADDR = 32'h0000_0010;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_0018;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xfer_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic [WAYS-1:0] ways_i;
  logic            busy_o, done_o, err_o;
  logic [31:0]     reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic            reg_write_o, reg_valid_o, reg_error_i, reg_ready_i;
  logic [3:0]      reg_wstrb_o;

  int          n_cmp = 0;
  int          n_err = 0;
  xfer_t       exp_q[$];
  xfer_t       got_q[$];
  logic [31:0] stat_list[$];
  int          err_at;
  int          dly_fixed;
  logic        exp_err;

  axi_llc_flush_seq #(
    .SetAssociativity(WAYS),
    .PollInterval(POLL),
    .MaxPolls(MAX_POLLS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ways_i(ways_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o), .reg_wdata_o(reg_wdata_o),
    .reg_wstrb_o(reg_wstrb_o), .reg_valid_o(reg_valid_o), .reg_rdata_i(reg_rdata_i),
    .reg_error_i(reg_error_i), .reg_ready_i(reg_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                               input logic [3:0] s);
    xfer_t x;
    x.addr = a; x.write = w; x.wdata = d; x.wstrb = s;
    return x;
  endfunction

  function automatic logic [31:0] stat_of(input int idx);
    return (idx < stat_list.size()) ? stat_list[idx] : 32'h0000_0000;
  endfunction

  // Transaction-level expectation: flush write, commit write, then polls.
  function automatic void build_model(input logic [7:0] ways);
    logic [31:0] m;
    m = {24'h000000, ways};
    exp_q.delete();
    exp_err = 1'b0;
    if (m == 32'h0) return;
    exp_q.push_back(mk(FLUSH_ADDR, 1'b1, m, 4'hF));
    if (err_at == 0) begin exp_err = 1'b1; return; end
    exp_q.push_back(mk(COMMIT_ADDR, 1'b1, 32'h1, 4'hF));
    if (err_at == 1) begin exp_err = 1'b1; return; end
    for (int r = 0; r < MAX_POLLS; r++) begin
      exp_q.push_back(mk(STATUS_ADDR, 1'b0, 32'h0, 4'h0));
      if (err_at == 2 + r) begin exp_err = 1'b1; return; end
      if ((stat_of(r) & m) == m) return;
    end
    exp_err = 1'b1;
  endfunction

  task automatic run_seq(input logic [7:0] ways, input string tag);
    xfer_t cur;
    logic  in_xfer, seen_done, finished;
    int    waited, delay, idle_run, first_done, xfer_idx, read_idx;
    build_model(ways);
    got_q.delete();
    cur = '0;
    in_xfer = 1'b0; seen_done = 1'b0; finished = 1'b0;
    waited = 0; delay = 0; idle_run = 0; first_done = -1; xfer_idx = 0; read_idx = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    ways_i  = ways;
    @(negedge clk_i);
    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      if (cyc == 0) begin
        n_cmp++;
        if ({busy_o, err_o} !== 2'b10) begin
          n_err++;
          $display("FAIL %s start_ack: busy/err=%b required 10", tag, {busy_o, err_o});
        end
      end
      start_i     = busy_o ? 1'($urandom_range(0, 1)) : 1'b0;
      ways_i      = 8'($urandom);
      reg_rdata_i = $urandom;
      reg_error_i = 1'($urandom_range(0, 1));
      reg_ready_i = 1'b0;
      if (seen_done) begin
        n_cmp++;
        if ({busy_o, done_o} !== 2'b00) begin
          n_err++;
          $display("FAIL %s end_idle: busy/done=%b required 00", tag, {busy_o, done_o});
        end
        finished = 1'b1;
      end else begin
        if (done_o) begin
          seen_done = 1'b1;
          first_done = cyc;
        end
        if (reg_valid_o) begin
          if (!in_xfer) begin
            in_xfer = 1'b1;
            waited  = 0;
            cur     = mk(reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o);
            delay   = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(0, 3));
            if (!reg_write_o) begin
              n_cmp++;
              if (idle_run != POLL) begin
                n_err++;
                $display("FAIL %s poll_gap: idle=%0d required %0d", tag, idle_run, POLL);
              end
            end
          end else begin
            n_cmp++;
            if (mk(reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o) !== cur) begin
              n_err++;
              $display("FAIL %s stable: got %h required %h", tag,
                       mk(reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o), cur);
            end
          end
          idle_run = 0;
          if (waited == delay) begin
            reg_ready_i = 1'b1;
            reg_error_i = (xfer_idx == err_at);
            if (!cur.write) begin
              reg_rdata_i = stat_of(read_idx);
              read_idx++;
            end
            got_q.push_back(cur);
            xfer_idx++;
            in_xfer = 1'b0;
          end
          waited++;
        end else begin
          idle_run++;
          if (in_xfer) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s valid_drop: valid=0 required 1", tag);
            in_xfer = 1'b0;
          end
          n_cmp++;
          if ({reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o} !== 69'h0) begin
            n_err++;
            $display("FAIL %s idle_fields: got %h required 0", tag,
                     {reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o});
          end
        end
      end
      @(negedge clk_i);
    end
    start_i = 1'b0; reg_ready_i = 1'b0; reg_error_i = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_err++;
      $display("FAIL %s timeout: finished=0 required 1", tag);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s xfer_count: got %0d required %0d", tag, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL %s xfer%0d: got %h required %h", tag, i, got_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (err_o !== exp_err) begin
      n_err++;
      $display("FAIL %s err: got %b required %b", tag, err_o, exp_err);
    end
    if (ways == 8'h00) begin
      n_cmp++;
      if (first_done != 0) begin
        n_err++;
        $display("FAIL %s zero_latency: done at %0d required 0", tag, first_done);
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; ways_i = 8'h00;
    reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = 32'h0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({busy_o, done_o, err_o, reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o}
        !== 73'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0",
               {busy_o, done_o, err_o, reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o});
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({busy_o, reg_valid_o} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release: busy/valid=%b required 00", {busy_o, reg_valid_o});
    end
  endtask

  task automatic test_basic();
    stat_list = '{32'h0000_0005}; err_at = -1; dly_fixed = 0;
    run_seq(8'h05, "basic");
  endtask

  task automatic test_ready_delay();
    stat_list = '{32'h0000_0005}; err_at = -1; dly_fixed = 3;
    run_seq(8'h05, "ready_delay");
  endtask

  task automatic test_poll_retry();
    stat_list = '{32'h1, 32'h1, 32'h1, 32'h5}; err_at = -1; dly_fixed = -1;
    run_seq(8'h05, "poll_retry");
  endtask

  task automatic test_timeout();
    stat_list.delete(); err_at = -1; dly_fixed = -1;
    run_seq(8'h05, "timeout");
  endtask

  task automatic test_bus_error();
    stat_list = '{32'h0000_00FF}; err_at = 1; dly_fixed = -1;
    run_seq(8'h81, "commit_error");
  endtask

  task automatic test_zero_ways();
    stat_list.delete(); err_at = -1; dly_fixed = -1;
    run_seq(8'h00, "zero_ways");
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1; ways_i = 8'h03;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      reg_ready_i = reg_valid_o & reg_write_o;
      reg_error_i = 1'b0;
      if (reg_valid_o && !reg_write_o) found = 1'b1;
      else @(negedge clk_i);
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_reach_read: found=0 required 1");
    end
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({reg_valid_o, busy_o, done_o} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_reset_async: valid/busy/done=%b required 000", {reg_valid_o, busy_o, done_o});
    end
    reg_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({busy_o, done_o} !== 2'b00) begin
      n_err++;
      $display("FAIL mid_reset_hold: busy/done=%b required 00", {busy_o, done_o});
    end
    rst_i = 1'b0;
    stat_list = '{32'h0000_0005}; err_at = -1; dly_fixed = -1;
    run_seq(8'h05, "after_reset");
  endtask

  task automatic test_random();
    logic [7:0] w;
    int         n;
    for (int it = 0; it < 25; it++) begin
      w = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      stat_list.delete();
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        stat_list.push_back(($urandom_range(0, 2) == 0) ? ($urandom | {24'h000000, w})
                                                         : 32'($urandom));
      end
      err_at    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
      dly_fixed = -1;
      run_seq(w, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_delay();
    test_poll_retry();
    test_timeout();
    test_bus_error();
    test_zero_ways();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
